// File: rtl/norm_round_pkg.sv
// Shared definitions for the normalize/round stage of the FMA add/sub datapath:
// round-to-nearest-even increment decision, exponent saturation limit and the
// bit positions inside the {overflow, underflow, inexact} flag vector.
package norm_round_pkg;

    localparam int SIZE_EXPONENT_DEFAULT = 8;

    // Largest biased exponent; it is reserved for infinity.
    function automatic int exp_max_of(input int size_exponent);
        return (1 << size_exponent) - 1;
    endfunction

    localparam int EXP_MAX = (1 << SIZE_EXPONENT_DEFAULT) - 1;

    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    // Round half to even: bump when above half, or exactly half with an odd LSB.
    function automatic logic rne_increment(input logic guard_bit,
                                           input logic sticky_bit,
                                           input logic lsb);
        return guard_bit & (sticky_bit | lsb);
    endfunction

endpackage

// File: rtl/leading_zero_counter.sv
// Combinational leading-zero counter. count is the number of zeros above the
// most significant one; an all-zero input yields count == width.
module leading_zero_counter #(
    parameter int width        = 49,
    parameter int size_counter = $clog2(width)
) (
    input  logic [width-1:0]        value,
    output logic [size_counter-1:0] count,
    output logic                    all_zero
);

    // above[i] is set when any bit strictly above i is one.
    logic [width-1:0]        above;
    logic [size_counter-1:0] term [width];

    assign above[width-1] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < width - 1; gi++) begin : g_above
            assign above[gi] = above[gi+1] | value[gi+1];
        end
        for (gi = 0; gi < width; gi++) begin : g_term
            // Only the leading one contributes its distance from the top.
            assign term[gi] = (value[gi] & ~above[gi]) ? size_counter'(width - 1 - gi) : '0;
        end
    endgenerate

    assign all_zero = ~|value;

    // OR together the one-hot selected distance terms.
    always_comb begin
        count = all_zero ? size_counter'(width) : '0;
        for (int i = 0; i < width; i++) begin
            count = count | term[i];
        end
    end

endmodule

// File: rtl/normalize_round.sv
// Normalize and round-to-nearest-even the unnormalized magnitude coming out of
// the FMA adder. Stage 1 finds the leading one and shifts it to the carry
// position; stage 2 rounds, handles zero/flush/saturation and holds the output.
// Optional macro NORM_ROUND_FLAGS_EN adds the flags_o port
// {overflow, underflow, inexact}.
module normalize_round
    import norm_round_pkg::*;
#(
    parameter int size_mantissa     = 24,
    parameter int size_exponent     = 8,
    parameter int size_mul_mantissa = 2 * size_mantissa,
    parameter int size_counter      = $clog2(size_mul_mantissa + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [size_mul_mantissa:0]   acc_i,
    input  logic [size_exponent+1:0]     exp_i,
    input  logic                         sign_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [size_mantissa-1:0]     mant_o,
    output logic [size_exponent-1:0]     exp_o,
    output logic                         sign_o,
`ifdef NORM_ROUND_FLAGS_EN
    output logic [2:0]                   flags_o,
`endif
    output logic                         zero_o
);

    localparam int AW = size_mul_mantissa + 1;
    // Exponent arithmetic width: input range plus the normalization shift.
    localparam int EW = size_exponent + 4;
    // Guard bit position once the leading one sits at bit size_mul_mantissa.
    localparam int GB = size_mul_mantissa - size_mantissa;
    localparam logic [EW-1:0]            EXP_MAX_W = EW'(exp_max_of(size_exponent));
    localparam logic [size_mantissa-1:0] HIDDEN    = size_mantissa'(1) << (size_mantissa - 1);

    // ---------------- stage 1: leading-one detect and shift ----------------
    logic [size_counter-1:0] lz;
    logic                    acc_zero;
    logic [AW-1:0]           s1_acc_next;
    logic [EW-1:0]           s1_exp_next;

    leading_zero_counter #(
        .width        (AW),
        .size_counter (size_counter)
    ) u_lzc (
        .value    (acc_i),
        .count    (lz),
        .all_zero (acc_zero)
    );

    assign s1_acc_next = acc_i << lz;
    // A leading one at bit size_mul_mantissa-2 (lz == 2) leaves the exponent unchanged.
    assign s1_exp_next = {{2{exp_i[size_exponent+1]}}, exp_i} + EW'(2)
                         - {{(EW - size_counter){1'b0}}, lz};

    logic                s1_valid_reg;
    logic [AW-1:0]       s1_acc_reg;
    logic [EW-1:0]       s1_exp_reg;
    logic                s1_sign_reg;
    logic                s1_zero_reg;

    // ---------------- stage 2: round and classify ----------------
    logic [size_mantissa-1:0] m_trunc;
    logic                     guard_bit;
    logic                     sticky_bit;
    logic [size_mantissa:0]   m_sum;
    logic [EW-1:0]            e2;
    logic                     ovf;
    logic                     unf;
    logic [size_mantissa-1:0] mant_next;
    logic [size_exponent-1:0] exp_next;
    logic                     zero_next;

    assign m_trunc    = s1_acc_reg[size_mul_mantissa -: size_mantissa];
    assign guard_bit  = s1_acc_reg[GB];
    assign sticky_bit = |s1_acc_reg[GB-1:0];
    assign m_sum      = {1'b0, m_trunc}
                        + (size_mantissa + 1)'(rne_increment(guard_bit, sticky_bit, m_trunc[0]));
    // A carry out of the rounding add means the mantissa became 10...0 one binade up.
    assign e2         = s1_exp_reg + EW'(m_sum[size_mantissa]);
    assign ovf        = !e2[EW-1] && (e2 >= EXP_MAX_W);
    assign unf        = e2[EW-1] || (e2 == '0);

    // Select the final payload: exact zero, flush to zero, saturate, or normal.
    always_comb begin
        mant_next = '0;
        exp_next  = '0;
        zero_next = 1'b0;
        if (s1_zero_reg || unf) begin
            zero_next = 1'b1;
        end else if (ovf) begin
            mant_next = HIDDEN;
            exp_next  = '1;
        end else begin
            mant_next = m_sum[size_mantissa] ? HIDDEN : m_sum[size_mantissa-1:0];
            exp_next  = e2[size_exponent-1:0];
        end
    end

`ifdef NORM_ROUND_FLAGS_EN
    logic [2:0] flags_next;
    logic [2:0] flags_reg;

    // Flags follow the same priority as the payload selection.
    always_comb begin
        flags_next = '0;
        if (s1_zero_reg) begin
            flags_next = '0;
        end else if (unf) begin
            flags_next[FLAG_UNF] = 1'b1;
            flags_next[FLAG_INX] = 1'b1;
        end else if (ovf) begin
            flags_next[FLAG_OVF] = 1'b1;
            flags_next[FLAG_INX] = 1'b1;
        end else begin
            flags_next[FLAG_INX] = guard_bit | sticky_bit;
        end
    end

    assign flags_o = flags_reg;
`endif

    // ---------------- handshake ----------------
    logic                     valid_o_reg;
    logic [size_mantissa-1:0] mant_reg;
    logic [size_exponent-1:0] exp_reg;
    logic                     sign_reg;
    logic                     zero_reg;
    logic                     s2_ready;
    logic                     s1_adv;
    logic                     in_fire;

    assign s2_ready = !valid_o_reg || ready_i;
    assign s1_adv   = s1_valid_reg && s2_ready;
    assign ready_o  = !s1_valid_reg || s2_ready;
    assign in_fire  = valid_i && ready_o;

    // Pipeline registers: stage 1 refills as it drains, output holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_acc_reg   <= '0;
            s1_exp_reg   <= '0;
            s1_sign_reg  <= 1'b0;
            s1_zero_reg  <= 1'b0;
            valid_o_reg  <= 1'b0;
            mant_reg     <= '0;
            exp_reg      <= '0;
            sign_reg     <= 1'b0;
            zero_reg     <= 1'b0;
`ifdef NORM_ROUND_FLAGS_EN
            flags_reg    <= '0;
`endif
        end else begin
            if (in_fire) begin
                s1_valid_reg <= 1'b1;
                s1_acc_reg   <= s1_acc_next;
                s1_exp_reg   <= s1_exp_next;
                s1_sign_reg  <= sign_i;
                s1_zero_reg  <= acc_zero;
            end else if (s1_adv) begin
                s1_valid_reg <= 1'b0;
            end

            if (s1_adv) begin
                valid_o_reg <= 1'b1;
                mant_reg    <= mant_next;
                exp_reg     <= exp_next;
                sign_reg    <= s1_sign_reg;
                zero_reg    <= zero_next;
`ifdef NORM_ROUND_FLAGS_EN
                flags_reg   <= flags_next;
`endif
            end else if (ready_i) begin
                valid_o_reg <= 1'b0;
            end
        end
    end

    assign valid_o = valid_o_reg;
    assign mant_o  = mant_reg;
    assign exp_o   = exp_reg;
    assign sign_o  = sign_reg;
    assign zero_o  = zero_reg;

endmodule

// File: tb/tb_normalize_round.sv
// Directed bench for normalize_round (24-bit mantissa, 8-bit exponent).
module tb_normalize_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [48:0] acc_i;
    logic [9:0]  exp_i;
    logic        sign_i;
    logic        valid_o;
    logic        ready_i;
    logic [23:0] mant_o;
    logic [7:0]  exp_o;
    logic        sign_o;
    logic        zero_o;
`ifdef NORM_ROUND_FLAGS_EN
    logic [2:0]  flags_o;
`endif

    always #5 clk = ~clk;

    normalize_round dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .acc_i   (acc_i),
        .exp_i   (exp_i),
        .sign_i  (sign_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .mant_o  (mant_o),
        .exp_o   (exp_o),
        .sign_o  (sign_o),
`ifdef NORM_ROUND_FLAGS_EN
        .flags_o (flags_o),
`endif
        .zero_o  (zero_o)
    );

    typedef struct {
        logic [48:0] acc;
        logic [9:0]  expi;
        logic        sign;
        logic [23:0] mant;
        logic [7:0]  expo;
        logic        zero;
        logic [2:0]  flags;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic add_vec(input logic [48:0] acc, input logic [9:0] expi, input logic sign,
                           input logic [23:0] mant, input logic [7:0] expo, input logic zero,
                           input logic [2:0] flags);
        vec_t v;
        v.acc = acc; v.expi = expi; v.sign = sign;
        v.mant = mant; v.expo = expo; v.zero = zero; v.flags = flags;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat with ready_i high: output must appear exactly two cycles after the offer.
    task automatic run_vec(input vec_t v, input int idx);
        acc_i = v.acc; exp_i = v.expi; sign_i = v.sign; valid_i = 1'b1;
        #1;
        check($sformatf("v%0d ready_o", idx), 64'(ready_o), 64'd1);
        tick();
        valid_i = 1'b0;
        check($sformatf("v%0d early valid_o", idx), 64'(valid_o), 64'd0);
        tick();
        check($sformatf("v%0d valid_o", idx), 64'(valid_o), 64'd1);
        check($sformatf("v%0d mant_o", idx), 64'(mant_o), 64'(v.mant));
        check($sformatf("v%0d exp_o", idx), 64'(exp_o), 64'(v.expo));
        check($sformatf("v%0d sign_o", idx), 64'(sign_o), 64'(v.sign));
        check($sformatf("v%0d zero_o", idx), 64'(zero_o), 64'(v.zero));
`ifdef NORM_ROUND_FLAGS_EN
        check($sformatf("v%0d flags_o", idx), 64'(flags_o), 64'(v.flags));
`endif
        $display("vec %0d acc=%h exp_i=%0d -> mant=%h exp=%0d zero=%0b sign=%0b",
                 idx, v.acc, $signed(v.expi), mant_o, exp_o, zero_o, sign_o);
    endtask

    logic [48:0] a46, a47, a48, all_46_22;
    logic [7:0]  bp_exp [4];
    logic [7:0]  got_exp [4];
    int          k, n_out;
    logic        accepted;

    initial begin
        a46 = 49'd1 << 46;
        a47 = 49'd1 << 47;
        a48 = 49'd1 << 48;
        all_46_22 = ((49'd1 << 47) - 49'd1) & ~((49'd1 << 22) - 49'd1);

        //       acc                              exp_i    s  mant       expo   z  flags
        add_vec(a46,                              10'd127, 0, 24'h800000, 8'd127, 0, 3'b000);
        add_vec(a47,                              10'd127, 1, 24'h800000, 8'd128, 0, 3'b000);
        add_vec(a48,                              10'd127, 0, 24'h800000, 8'd129, 0, 3'b000);
        add_vec(a46 | (49'd1 << 22),              10'd127, 0, 24'h800000, 8'd127, 0, 3'b001);
        add_vec(a46 | (49'd1 << 23) | (49'd1 << 22), 10'd127, 1, 24'h800002, 8'd127, 0, 3'b001);
        add_vec(all_46_22,                        10'd127, 0, 24'h800000, 8'd128, 0, 3'b001);
        add_vec(a46 | (49'd1 << 22) | 49'd1,      10'd127, 0, 24'h800001, 8'd127, 0, 3'b001);
        add_vec(a48 | (49'd1 << 24),              10'd127, 0, 24'h800000, 8'd129, 0, 3'b001);
        add_vec(a48 | (49'd1 << 25) | (49'd1 << 24), 10'd127, 0, 24'h800002, 8'd129, 0, 3'b001);
        add_vec(49'd0,                            10'd127, 1, 24'h000000, 8'd0,   1, 3'b000);
        add_vec(a46,                              10'd255, 0, 24'h800000, 8'hFF,  0, 3'b101);
        add_vec(a46,                              10'd0,   1, 24'h000000, 8'd0,   1, 3'b011);
        add_vec(a46,                              10'h3FB, 0, 24'h000000, 8'd0,   1, 3'b011);
        add_vec(a46,                              10'd254, 0, 24'h800000, 8'd254, 0, 3'b000);
        add_vec(a46,                              10'd1,   0, 24'h800000, 8'd1,   0, 3'b000);
        add_vec(49'd1,                            10'd200, 0, 24'h800000, 8'd154, 0, 3'b000);
        add_vec(a47,                              10'd254, 0, 24'h800000, 8'hFF,  0, 3'b101);
        add_vec(all_46_22,                        10'd254, 1, 24'h800000, 8'hFF,  0, 3'b101);

        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        acc_i = '0; exp_i = '0; sign_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset valid_o", 64'(valid_o), 64'd0);
        check("reset mant_o", 64'(mant_o), 64'd0);
        check("reset exp_o", 64'(exp_o), 64'd0);
        check("reset sign_o", 64'(sign_o), 64'd0);
        check("reset zero_o", 64'(zero_o), 64'd0);
        check("reset ready_o", 64'(ready_o), 64'd1);
`ifdef NORM_ROUND_FLAGS_EN
        check("reset flags_o", 64'(flags_o), 64'd0);
`endif

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Backpressure: 4 beats offered while downstream stalls for 3 cycles.
        tick();
        for (int i = 0; i < 4; i++) bp_exp[i] = 8'(100 + i);
        ready_i = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            acc_i = a46; exp_i = 10'(bp_exp[k]); sign_i = 1'b0; valid_i = 1'b1;
            #1;
            accepted = ready_o;
            tick();
            if (accepted) k++;
        end
        check("bp accepted", 64'(k), 64'd2);
        check("bp ready_o low", 64'(ready_o), 64'd0);
        check("bp valid_o", 64'(valid_o), 64'd1);
        check("bp exp_o held", 64'(exp_o), 64'(bp_exp[0]));
        tick();
        check("bp exp_o still held", 64'(exp_o), 64'(bp_exp[0]));
        check("bp mant_o held", 64'(mant_o), 64'h800000);
        ready_i = 1'b1;
        n_out = 0;
        for (int cyc = 0; cyc < 20 && n_out < 4; cyc++) begin
            if (k < 4) begin
                acc_i = a46; exp_i = 10'(bp_exp[k]); valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            #1;
            accepted = valid_i && ready_o;
            if (valid_o) begin
                got_exp[n_out] = exp_o;
                $display("bp beat %0d exp=%0d mant=%h", n_out, exp_o, mant_o);
                n_out++;
            end
            tick();
            if (accepted) k++;
        end
        valid_i = 1'b0;
        check("bp beats out", 64'(n_out), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < n_out) check($sformatf("bp order %0d", i), 64'(got_exp[i]), 64'(bp_exp[i]));
        end
        tick();
        check("bp drained", 64'(valid_o), 64'd0);

        // Reset while both stages hold a beat.
        ready_i = 1'b0;
        acc_i = a46; exp_i = 10'd50; valid_i = 1'b1;
        tick();
        exp_i = 10'd51;
        tick();
        valid_i = 1'b0;
        check("pre-rst valid_o", 64'(valid_o), 64'd1);
        check("pre-rst ready_o", 64'(ready_o), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("post-rst valid_o", 64'(valid_o), 64'd0);
        check("post-rst ready_o", 64'(ready_o), 64'd1);
        ready_i = 1'b1;
        tick();
        check("post-rst stale beat", 64'(valid_o), 64'd0);
        run_vec(vecs[1], 100);
        tick();
        check("post-rst drained", 64'(valid_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
